// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin FIFO arbiter.
package wrr_pkg;

  localparam int MAX_CH = 16;

  typedef logic [3:0] weight_t;

  typedef enum logic {
    IDLE,
    GRANT
  } wrr_state_e;

  // Lowest offset from start (with wrap) whose mask bit is set.
  function automatic logic [3:0] next_eligible(
    input logic [MAX_CH-1:0] mask,
    input logic [3:0]        start
  );
    logic [3:0] idx;
    next_eligible = start;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = start + 4'(i);
      if (mask[idx]) next_eligible = idx;
    end
  endfunction

endpackage

// File: rtl/wrr_chan_fifo.sv
// Per-channel first-word-fall-through FIFO.
// head always shows the oldest entry while empty is low.
module wrr_chan_fifo #(
  parameter type data_t = logic [7:0],
  parameter int  DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  data_t                      push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output data_t                      head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  data_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [LVL_W-1:0] lvl_q;
  logic [LVL_W-1:0] lvl_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = lvl_q;
  assign head    = mem_q[rd_q];

  always_comb begin
    lvl_d = lvl_q;
    if (do_push && !do_pop) lvl_d = lvl_q + LVL_W'(1);
    else if (do_pop && !do_push) lvl_d = lvl_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset; only occupied slots are ever read out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/wrr_fifo_arbiter.sv
// N-channel FWFT ingress buffers drained by a weighted
// round-robin arbiter onto one valid/ready output.
module wrr_fifo_arbiter
  import wrr_pkg::*;
#(
  parameter type     data_t = logic [7:0],
  parameter int      NUM_CH = 4,
  parameter int      DEPTH  = 8,
  parameter weight_t WEIGHT [NUM_CH] = '{default: 4'd1}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid [NUM_CH],
  output logic                       in_ready [NUM_CH],
  input  data_t                      in_data  [NUM_CH],
  output logic                       out_valid,
  input  logic                       out_ready,
  output data_t                      out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic [$clog2(DEPTH+1)-1:0] level [NUM_CH]
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  function automatic logic any_weight();
    for (int c = 0; c < NUM_CH; c++) begin
      if (WEIGHT[c] != '0) return 1'b1;
    end
    return 1'b0;
  endfunction

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("NUM_CH must be in 2..16");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (!any_weight()) begin : g_bad_weight
    $error("at least one WEIGHT must be non-zero");
  end

  wrr_state_e        st_q, st_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   last_q, last_d;
  weight_t           credit_q, credit_d;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push_ok;
  logic [NUM_CH-1:0] pop_ch;
  logic [MAX_CH-1:0] elig;
  logic [MAX_CH-1:0] post;
  logic [MAX_CH-1:0] cand;
  logic [CH_W-1:0]   nxt;
  data_t             head [NUM_CH];
  logic              pop;
  logic              keep;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push_ok[c]  = in_valid[c] && !full[c];
    assign pop_ch[c]   = pop && (gnt_q == CH_W'(c));
    assign in_ready[c] = !full[c];
    assign elig[c]     = (WEIGHT[c] != '0) && !empty[c];

    wrr_chan_fifo #(
      .data_t(data_t),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (in_valid[c]),
      .push_data(in_data[c]),
      .pop      (pop_ch[c]),
      .full     (full[c]),
      .empty    (empty[c]),
      .level    (level[c]),
      .head     (head[c])
    );
  end

  if (NUM_CH < MAX_CH) begin : g_pad
    assign elig[MAX_CH-1:NUM_CH] = '0;
  end

  assign pop = out_valid && out_ready;

  // Granted channel stays eligible if the pop leaves it non-empty.
  assign keep = (level[gnt_q] > LVL_W'(1)) || push_ok[gnt_q];

  always_comb begin
    post        = elig;
    post[gnt_q] = keep;
    cand        = (st_q == IDLE) ? elig : post;
    nxt         = CH_W'(next_eligible(cand, 4'(last_q) + 4'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      gnt_q    <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
      credit_q <= '0;
    end else if (flush) begin
      st_q     <= IDLE;
      gnt_q    <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
      credit_q <= '0;
    end else begin
      st_q     <= st_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    credit_d = credit_q;
    unique case (st_q)
      IDLE: begin
        if (|elig) begin
          st_d     = GRANT;
          gnt_d    = nxt;
          last_d   = nxt;
          credit_d = WEIGHT[nxt];
        end
      end
      GRANT: begin
        if (pop) begin
          credit_d = credit_q - 4'd1;
          if (credit_q == 4'd1 || !keep) begin
            if (|post) begin
              gnt_d    = nxt;
              last_d   = nxt;
              credit_d = WEIGHT[nxt];
            end else begin
              st_d = IDLE;
            end
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (st_q == GRANT);
    out_ch    = gnt_q;
    out_data  = out_valid ? head[gnt_q] : '0;
  end

endmodule

// File: doc/wrr_fifo_arbiter.md
# wrr_fifo_arbiter

Parametrised N-channel ingress buffer with weighted round-robin egress. Each channel owns a first-word-fall-through FIFO holding a type-parameterised payload. A single arbiter drains the FIFOs onto one valid/ready output, granting each channel a burst of up to its per-channel weight before rotating. It sits between independent producers and a shared downstream consumer, and replaces fixed-width, single-mode muxes with one configurable block.

## Interface
- `data_t`, `logic [7:0]`: type parameter for the payload carried per transfer.
- `NUM_CH`, 4: channel count; must be 2..16.
- `DEPTH`, 8: entries per channel FIFO; power of two, at least 2.
- `WEIGHT[NUM_CH]`, `'{default: 4'd1}`: unpacked array of 4-bit burst weights. 0 means the channel is disabled for egress.
- `localparam CH_W = $clog2(NUM_CH)`, `localparam LVL_W = $clog2(DEPTH+1)`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset; deassertion is synchronised externally.
- `flush` in 1: synchronous clear of all FIFOs and arbiter state.
- `in_valid[NUM_CH]` in 1 each: producer has data.
- `in_ready[NUM_CH]` out 1 each: channel FIFO not full.
- `in_data[NUM_CH]` in `data_t` each: payload.
- `out_valid` out 1: granted channel has a head entry.
- `out_ready` in 1: consumer accepts.
- `out_data` out `data_t`: head of granted FIFO.
- `out_ch` out `CH_W`: index of granted channel.
- `level[NUM_CH]` out `LVL_W` each: current FIFO occupancy.

## Operation
- Push when `in_valid[c] && in_ready[c]`. `in_ready[c] = (level[c] != DEPTH)`. There is no pass-through: a full FIFO refuses a push even when a pop happens in the same cycle.
- Pop occurs only on the granted channel, when `out_valid && out_ready`.
- A simultaneous push and pop on one channel leaves `level` unchanged. Pointers wrap modulo `DEPTH`.
- Arbiter FSM, state register `st ∈ {IDLE, GRANT}`, plus `gnt` (CH_W bits) and `credit` (4 bits).
- IDLE: `out_valid = 0`. If any enabled channel is non-empty, go to GRANT. The new `gnt` is the first enabled, non-empty channel searched from `last+1` with wrap. `credit = WEIGHT[gnt]`.
- GRANT: `out_valid = 1` and `out_data` = head of `gnt`. On a pop, `credit` decrements.
- The grant ends when the pop exhausts `credit` (credit == 1 at the pop) or empties the FIFO. The next state is computed from post-pop occupancy, searching from `gnt+1`:
  - another eligible channel found: GRANT on it, no bubble cycle;
  - only `gnt` remains eligible: re-grant `gnt` with fresh credit;
  - nothing eligible: IDLE.
- `last` records the most recent `gnt`; it resets to `NUM_CH-1`, so channel 0 has first priority.
- While `out_valid = 1`, `out_data` and `out_ch` are stable until the handshake; the grant never changes without a pop.
- A disabled channel (weight 0) still accepts pushes until full, but is never granted.
- `flush`: at the next edge all levels become 0, `st = IDLE`, and `last = NUM_CH-1`. Pushes and pops in the flush cycle are discarded. `in_ready` and `out_valid` respond from the following cycle.

## Timing
- Reset values: `in_ready = 1` for every channel, `out_valid = 0`, `out_data = '0`, `out_ch = 0`, `level = 0`, `st = IDLE`.
- Latency: a push at edge n into an empty system gives `out_valid = 1` in cycle n+1 (edge n loads the FIFO, edge n+1 sets GRANT). Minimum latency is 2 edges from `in_valid` to visible output.
- Throughput: one transfer per cycle while any eligible channel holds data.
- `rst_n` asserted mid-burst clears everything immediately. The partial burst and the queued data are lost.
- `level` is registered and reflects the count after the previous edge.

## Structure
- Package `wrr_pkg` holds:
  - `typedef logic [3:0] weight_t`;
  - the `MAX_CH = 16` constant;
  - the state enum `wrr_state_e {IDLE, GRANT}`;
  - a function `next_eligible(mask, start)` returning the rotating first-set index.
- Sub-module `wrr_chan_fifo`:
  - parameters: type `data_t` and `DEPTH`;
  - ports: push/pop, full/empty, level, head, flush;
  - instantiated `NUM_CH` times in a generate loop.
- Elaboration-time assertions check `NUM_CH`, the power-of-two `DEPTH`, and that at least one `WEIGHT` is non-zero.

## Test plan
- **Basic order:** NUM_CH=4, weights all 1, push A0,A1 on ch0 and B0 on ch2, `out_ready` held high. Required output: A0 (ch0), B0 (ch2), A1 (ch0), then `out_valid = 0`.
- **Weights:** WEIGHT = '{3,1,0,2}, all channels pre-filled with 6 entries. Required ch sequence: 0,0,0,1,3,3,0,0,0,1,3,3. Ch2 is never output and its `level` stays 6.
- **Full boundary:** DEPTH=8, fill ch1 to 8, `out_ready = 0`. Required: `in_ready[1] = 0`. A push and a pop together on the full FIFO leave `level` at 7 the next cycle, with `in_ready` back to 1.
- **Backpressure:** toggle `out_ready` pseudo-randomly. Required: `out_data` and `out_ch` are stable whenever `out_valid && !out_ready`, and there is no loss or duplication across 1000 transfers.
- **Flush mid-burst:** assert `flush` during the second of a 3-credit burst. Next cycle: all levels 0, `out_valid = 0`. The next push on ch3 is granted first after ch0..2 are found empty.
- **Reset mid-operation:** drop `rst_n` asynchronously mid-cycle. Required: outputs take their reset values without waiting for a clock edge.
